// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified-memory port arbiter.
// The address check lives here so the top and any checker agree on it.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        ACK    = 2'd2
    } arb_state_e;

    typedef enum logic {
        PORT_IF = 1'b0,
        PORT_D  = 1'b1
    } port_id_e;

    localparam int         MEM_BYTES       = 16384;
    localparam logic [1:0] WORD_ALIGN_MASK = 2'b11;

    // Misaligned word access or any bit set at/above the implemented width.
    function automatic logic addr_err(input logic [31:0] addr, input int addr_bits);
        logic misaligned;
        logic out_of_range;
        misaligned   = (addr[1:0] & WORD_ALIGN_MASK) != 2'b00;
        out_of_range = (addr >> addr_bits) != 32'd0;
        return misaligned | out_of_range;
    endfunction

endpackage

// File: rtl/arb_rr2.sv
// Two-way grant: round-robin against the last served port, or fixed data
// priority. Bit 0 is the fetch port, bit 1 the data port; output is one-hot.
module arb_rr2
    import mem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_grant,
    input  logic       prio_mode,
    output logic [1:0] grant
);

    // Resolve the request pair into a one-hot grant.
    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01: grant = 2'b01;
            2'b10: grant = 2'b10;
            2'b11: begin
                if (prio_mode) begin
                    grant = 2'b10;
                end else if (last_grant == PORT_IF) begin
                    grant = 2'b10;
                end else begin
                    grant = 2'b01;
                end
            end
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single memory port between instruction fetch and load/store:
// grant in IDLE, one memory cycle in ACCESS, one-cycle ack in ACK.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int DATA_PRIORITY = 0,
    parameter int ADDR_BITS     = $clog2(MEM_BYTES)
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_ack,
    output logic [31:0] if_rdata,
    output logic        if_err,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_ack,
    output logic [31:0] d_rdata,
    output logic        d_err,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_wr_en,
    input  logic [31:0] mem_rdata,
    output logic        busy
);

    localparam logic PRIO_MODE = (DATA_PRIORITY != 0) ? 1'b1 : 1'b0;

    arb_state_e  state_r, state_nxt_s;
    port_id_e    port_r, last_grant_r;
    logic [31:0] addr_r, wdata_r, rdata_r;
    logic        we_r, err_r;
    logic [1:0]  grant_s;
    logic [31:0] sel_addr_s;

    arb_rr2 u_arb (
        .req        ({d_req, if_req}),
        .last_grant (last_grant_r),
        .prio_mode  (PRIO_MODE),
        .grant      (grant_s)
    );

    // Address of whichever port wins this cycle.
    always_comb begin
        sel_addr_s = 32'd0;
        if (grant_s[1]) begin
            sel_addr_s = d_addr;
        end else begin
            sel_addr_s = if_addr;
        end
    end

    // State register plus latched request fields and the response word.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r      <= IDLE;
            port_r       <= PORT_IF;
            last_grant_r <= PORT_D;
            addr_r       <= 32'd0;
            wdata_r      <= 32'd0;
            rdata_r      <= 32'd0;
            we_r         <= 1'b0;
            err_r        <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            case (state_r)
                IDLE: begin
                    if (grant_s != 2'b00) begin
                        port_r  <= grant_s[1] ? PORT_D : PORT_IF;
                        addr_r  <= sel_addr_s;
                        we_r    <= grant_s[1] & d_we;
                        wdata_r <= grant_s[1] ? d_wdata : 32'd0;
                        err_r   <= addr_err(sel_addr_s, ADDR_BITS);
                    end
                end
                ACCESS:  rdata_r <= err_r ? 32'd0 : mem_rdata;
                ACK:     last_grant_r <= port_r;
                default: ;
            endcase
        end
    end

    // Fixed three-step sequence; only IDLE waits on a request.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (grant_s != 2'b00) begin
                    state_nxt_s = ACCESS;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            ACCESS:  state_nxt_s = ACK;
            ACK:     state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // Decode memory-side and requester-side outputs from the held registers.
    always_comb begin
        mem_addr  = 32'd0;
        mem_wdata = 32'd0;
        mem_wr_en = 1'b0;
        if_ack    = 1'b0;
        if_rdata  = 32'd0;
        if_err    = 1'b0;
        d_ack     = 1'b0;
        d_rdata   = 32'd0;
        d_err     = 1'b0;
        busy      = (state_r != IDLE);
        if (state_r == ACCESS) begin
            mem_addr  = addr_r;
            mem_wdata = wdata_r;
            mem_wr_en = we_r & ~err_r & reset_n;
        end else if (state_r == ACK) begin
            // A write cycle captured the old word; never show it to the requester.
            if (port_r == PORT_D) begin
                d_ack   = 1'b1;
                d_rdata = we_r ? 32'd0 : rdata_r;
                d_err   = err_r;
            end else begin
                if_ack   = 1'b1;
                if_rdata = rdata_r;
                if_err   = err_r;
            end
        end else begin
            busy = 1'b0;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: round-robin instance with a memory model for the main
// vectors, plus a data-priority instance for the contention case.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    int          tests = 0;
    int          fails = 0;

    logic        if_req, if_ack, if_err, d_req, d_we, d_ack, d_err, mem_wr_en, busy;
    logic [31:0] if_addr, if_rdata, d_addr, d_wdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
    logic        if_req1, if_ack1, if_err1, d_req1, d_we1, d_ack1, d_err1, mem_wr_en1, busy1;
    logic [31:0] if_addr1, if_rdata1, d_addr1, d_wdata1, d_rdata1, mem_addr1, mem_wdata1, mem_rdata1;

    logic [31:0] mem [0:4095];

    always #5 clk = ~clk;

    mem_port_arbiter #(.DATA_PRIORITY(0), .ADDR_BITS(14)) dut0 (
        .clk(clk), .reset_n(reset_n),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata), .if_err(if_err),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata), .d_err(d_err),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wr_en(mem_wr_en),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    mem_port_arbiter #(.DATA_PRIORITY(1), .ADDR_BITS(14)) dut1 (
        .clk(clk), .reset_n(reset_n),
        .if_req(if_req1), .if_addr(if_addr1), .if_ack(if_ack1), .if_rdata(if_rdata1), .if_err(if_err1),
        .d_req(d_req1), .d_we(d_we1), .d_addr(d_addr1), .d_wdata(d_wdata1),
        .d_ack(d_ack1), .d_rdata(d_rdata1), .d_err(d_err1),
        .mem_addr(mem_addr1), .mem_wdata(mem_wdata1), .mem_wr_en(mem_wr_en1),
        .mem_rdata(mem_rdata1), .busy(busy1)
    );

    assign mem_rdata  = mem[mem_addr[13:2]];
    assign mem_rdata1 = mem_addr1 ^ 32'hFFFF_0000;

    always @(posedge clk) begin
        if (mem_wr_en) mem[mem_addr[13:2]] <= mem_wdata;
    end

    typedef struct {
        logic        is_d;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_wr;
    } vec_t;

    vec_t vecs [12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One transaction on dut0; ack expected on the second negedge after driving.
    task automatic run_txn(input string tag, input vec_t v);
        int          ack_at = -1;
        int          wr_cnt = 0;
        int          busy_cnt = 0;
        int          other = 0;
        logic [31:0] got_rdata = 32'd0;
        logic        got_err = 1'b0;
        @(negedge clk);
        if (v.is_d) begin
            d_req = 1'b1; d_we = v.we; d_addr = v.addr; d_wdata = v.wdata;
        end else begin
            if_req = 1'b1; if_addr = v.addr;
        end
        for (int i = 0; i < 6 && ack_at < 0; i++) begin
            @(negedge clk);
            if (mem_wr_en) wr_cnt++;
            if (busy) busy_cnt++;
            if (v.is_d ? if_ack : d_ack) other++;
            if (v.is_d ? d_ack : if_ack) begin
                ack_at    = i;
                got_rdata = v.is_d ? d_rdata : if_rdata;
                got_err   = v.is_d ? d_err : if_err;
                if_req    = 1'b0;
                d_req     = 1'b0;
            end
        end
        if_req = 1'b0;
        d_req  = 1'b0;
        check({tag, "_latency"}, ack_at, 32'd1);
        check({tag, "_rdata"}, got_rdata, v.exp_rdata);
        check({tag, "_err"}, {31'd0, got_err}, {31'd0, v.exp_err});
        check({tag, "_wr_cycles"}, wr_cnt, v.exp_wr);
        check({tag, "_busy_cycles"}, busy_cnt, 32'd2);
        check({tag, "_other_ack"}, other, 32'd0);
    endtask

    initial begin
        int          n;
        int          ack_cyc [4];
        int          ack_port [4];
        int          both;
        int          seen;
        for (int i = 0; i < 4096; i++) mem[i] = 32'd0;
        mem[12'h010] = 32'hDEAD_BEEF;
        mem[12'h040] = 32'h0BAD_F00D;
        mem[12'h080] = 32'h1111_1111;
        mem[12'hFFF] = 32'hA5A5_5A5A;

        vecs[0]  = '{1'b0, 1'b0, 32'h0000_0040, 32'h0,          32'hDEAD_BEEF, 1'b0, 0};
        vecs[1]  = '{1'b1, 1'b1, 32'h0000_0100, 32'hCAFE_F00D, 32'h0,          1'b0, 1};
        vecs[2]  = '{1'b1, 1'b0, 32'h0000_0100, 32'h0,          32'hCAFE_F00D, 1'b0, 0};
        vecs[3]  = '{1'b1, 1'b1, 32'h0000_0102, 32'h5555_5555, 32'h0,          1'b1, 0};
        vecs[4]  = '{1'b1, 1'b0, 32'h0000_0100, 32'h0,          32'hCAFE_F00D, 1'b0, 0};
        vecs[5]  = '{1'b0, 1'b0, 32'h0000_4000, 32'h0,          32'h0,          1'b1, 0};
        vecs[6]  = '{1'b0, 1'b0, 32'h0000_0041, 32'h0,          32'h0,          1'b1, 0};
        vecs[7]  = '{1'b1, 1'b0, 32'h8000_0000, 32'h0,          32'h0,          1'b1, 0};
        vecs[8]  = '{1'b1, 1'b0, 32'h0000_3FFC, 32'h0,          32'hA5A5_5A5A, 1'b0, 0};
        vecs[9]  = '{1'b0, 1'b0, 32'h0000_0100, 32'h0,          32'hCAFE_F00D, 1'b0, 0};
        vecs[10] = '{1'b1, 1'b1, 32'h0000_3FFC, 32'h1234_5678, 32'h0,          1'b0, 1};
        vecs[11] = '{1'b1, 1'b0, 32'h0000_3FFC, 32'h0,          32'h1234_5678, 1'b0, 0};

        reset_n = 1'b0;
        if_req = 1'b0; if_addr = 32'd0; d_req = 1'b0; d_we = 1'b0; d_addr = 32'd0; d_wdata = 32'd0;
        if_req1 = 1'b0; if_addr1 = 32'd0; d_req1 = 1'b0; d_we1 = 1'b0; d_addr1 = 32'd0; d_wdata1 = 32'd0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_acks", {30'd0, if_ack, d_ack}, 32'd0);
        check("rst_mem_if", {mem_addr ^ mem_wdata, 31'd0, mem_wr_en} != 64'd0 ? 32'd1 : 32'd0, 32'd0);
        check("rst_rdata", if_rdata | d_rdata, 32'd0);

        for (int k = 0; k < 12; k++) run_txn($sformatf("vec%0d", k), vecs[k]);
        check("err_write_mem_intact", mem[12'h040], 32'hCAFE_F00D);

        // Round-robin contention: last served was D, so IF goes first.
        @(negedge clk);
        if_req = 1'b1; if_addr = 32'h40; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100;
        n = 0; both = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (if_ack && d_ack) both++;
            if ((if_ack || d_ack) && n < 4) begin
                ack_cyc[n]  = i;
                ack_port[n] = d_ack ? 1 : 0;
                if (if_ack) check("rr_if_rdata", if_rdata, 32'hDEAD_BEEF);
                if (d_ack) check("rr_d_rdata", d_rdata, 32'hCAFE_F00D);
                n++;
            end
        end
        if_req = 1'b0; d_req = 1'b0;
        check("rr_count", n, 32'd4);
        check("rr_both", both, 32'd0);
        for (int k = 0; k < 4 && k < n; k++) begin
            check($sformatf("rr_cycle%0d", k), ack_cyc[k], 1 + 3 * k);
            check($sformatf("rr_port%0d", k), ack_port[k], k % 2);
        end

        // Data-priority contention on dut1: D every time, IF only once D drops.
        @(negedge clk);
        if_req1 = 1'b1; if_addr1 = 32'h40; d_req1 = 1'b1; d_we1 = 1'b0; d_addr1 = 32'h100;
        n = 0; both = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (if_ack1) both++;
            if (d_ack1) begin
                if (n < 4) ack_cyc[n] = i;
                check("prio_d_rdata", d_rdata1, 32'hFFFF_0100);
                n++;
            end
        end
        d_req1 = 1'b0;
        check("prio_d_count", n, 32'd4);
        check("prio_if_starved", both, 32'd0);
        check("prio_d_cycle3", ack_cyc[3], 32'd10);
        seen = -1;
        for (int i = 0; i < 6 && seen < 0; i++) begin
            @(negedge clk);
            if (if_ack1) begin
                seen = i;
                check("prio_if_rdata", if_rdata1, 32'hFFFF_0040);
                if_req1 = 1'b0;
            end
        end
        if_req1 = 1'b0;
        check("prio_if_latency", seen, 32'd1);

        // Reset during the ACCESS cycle of a write to 0x200.
        @(negedge clk);
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h200; d_wdata = 32'h2222_2222;
        @(negedge clk);
        check("midrst_wr_before", {31'd0, mem_wr_en}, 32'd1);
        #1 reset_n = 1'b0; d_req = 1'b0; d_we = 1'b0;
        #1;
        check("midrst_wr_drop", {31'd0, mem_wr_en}, 32'd0);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        seen = 0;
        repeat (4) begin
            @(negedge clk);
            if (d_ack || if_ack) seen++;
        end
        check("midrst_no_ack", seen, 32'd0);
        check("midrst_mem", mem[12'h080], 32'h1111_1111);
        run_txn("midrst_readback", '{1'b1, 1'b0, 32'h200, 32'h0, 32'h1111_1111, 1'b0, 0});

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the unified 16 KiB instruction/data memory's single access port between two requesters: instruction fetch (IF, read-only) and load/store (D, read/write).
- Serialises requests with a req/ack handshake, arbitrates round-robin (or fixed data priority), and registers read data.
- Rejects misaligned or out-of-range addresses with an error response instead of touching memory.
- Sits between the CPU front-end/LSU and the memory block.

Parameters:
- DATA_PRIORITY, 0, 1 = D always wins a simultaneous request; 0 = round-robin.
- ADDR_BITS, 14, implemented byte-address width; any address bit at or above ADDR_BITS set is an out-of-range error.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- if_req  in  1  instruction fetch request; held until if_ack.
- if_addr  in  32  fetch byte address.
- if_ack  out  1  one-cycle response pulse.
- if_rdata  out  32  fetched word; valid while if_ack=1.
- if_err  out  1  misaligned or out-of-range; valid while if_ack=1.
- d_req  in  1  data request; held until d_ack.
- d_we  in  1  1 = write, 0 = read.
- d_addr  in  32  data byte address.
- d_wdata  in  32  write data.
- d_ack  out  1  one-cycle response pulse.
- d_rdata  out  32  load data; valid while d_ack=1.
- d_err  out  1  error flag; valid while d_ack=1.
- mem_addr  out  32  memory address (to memory data_addr).
- mem_wdata  out  32  memory write data.
- mem_wr_en  out  1  memory write enable; memory writes on the rising edge.
- mem_rdata  in  32  combinational memory read data.
- busy  out  1  1 whenever state != IDLE.

Interface decision: one clock (clk); reset is asynchronous and active-low (reset_n).

Behaviour:

Reset:
- State = IDLE, last_grant = D, all latched fields = 0.
- All outputs = 0.
- Reset asserted mid-transaction: mem_wr_en drops combinationally, so no write occurs. The pending transaction is lost with no ack; the requester re-issues it.

FSM (3 states):
- IDLE:
  - If any req is high at the rising edge, choose a winner.
  - Latch the winner's port id, addr, we (forced to 0 for IF), wdata and err = (addr[1:0] != 0) OR (addr[31:ADDR_BITS] != 0).
  - Go to ACCESS.
- ACCESS:
  - Drive mem_addr = latched addr and mem_wdata = latched wdata.
  - mem_wr_en = latched we AND NOT err.
  - At the edge, capture rdata = err ? 0 : mem_rdata (a write cycle also captures the old word, but only reads expose it). Go to ACK.
- ACK:
  - Assert the granted port's ack for exactly one cycle, with rdata/err from the response register.
  - For a write, the ack-cycle rdata is 0.
  - Update last_grant to the granted port. Go to IDLE.

Latency and throughput:
- Request sampled at edge N; ack high during cycle N+2.
- Write is committed at the edge that ends ACCESS.
- Maximum throughput: 1 transaction per 3 cycles; no arbitration in ACK.

Outside ACCESS:
- mem_addr = 0, mem_wdata = 0, mem_wr_en = 0.
- Non-granted port outputs = 0.

Arbitration:
- Single request: it wins.
- Both requesting, DATA_PRIORITY=0: the port not equal to last_grant wins (IF first after reset).
- Both requesting, DATA_PRIORITY=1: D wins.

Handshake:
- Requester keeps req and fields stable until ack; fields are latched at grant, so later changes are ignored.
- req still high in the cycle after ack is a new request.
- Dropping req before ack is illegal; the latched transaction completes anyway.

Error path:
- Memory is never written, and rdata = 0.

Decomposition:
- Package mem_arb_pkg:
  - state enum {IDLE, ACCESS, ACK}.
  - port id enum {PORT_IF, PORT_D}.
  - MEM_BYTES = 16384.
  - WORD_ALIGN_MASK = 2'b11.
- Sub-module arb_rr2: 2-way round-robin/fixed-priority grant with inputs req[1:0], last_grant, prio_mode and a one-hot grant output; purely combinational.
- The FSM and response registers stay in the top level.

Test Plan:
- Reset then IF read: mem[0x10] = 0xDEADBEEF; if_req=1, if_addr=0x40 at edge 0 → if_ack=1, if_rdata=0xDEADBEEF in cycle 2; mem_wr_en stays 0 throughout.
- D write then read back: d_we=1, d_addr=0x100, d_wdata=0xCAFEF00D → mem_wr_en=1 only in the ACCESS cycle, then d_ack. A following read of 0x100 → d_rdata=0xCAFEF00D.
- Contention with DATA_PRIORITY=0: if_req and d_req held high together → grants alternate IF, D, IF, D; each ack is 3 cycles apart and neither port starves.
- Contention with DATA_PRIORITY=1: same stimulus → D served every time; IF is served only when d_req is low.
- Errors: d_we=1, d_addr=0x102 → d_err=1, d_rdata=0, memory unchanged. if_addr=0x4000 → if_err=1.
- Reset mid-operation: reset_n=0 during ACCESS of a write to 0x200 (old value 0x11111111) → mem_wr_en falls immediately, mem[0x200] stays 0x11111111, no ack, busy=0.
